// File: rtl/mem_stage_lsu_if.sv
// Memory-side bus bundle of the M-stage LSU: the single-cycle data RAM port
// and the req/ack peripheral port. The LSU takes the master view.
interface mem_stage_lsu_if;
    // Data RAM port (asynchronous read)
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Peripheral req/ack port
    logic        per_req;
    logic        per_we;
    logic [31:0] per_addr;
    logic [3:0]  per_be;
    logic [31:0] per_wdata;
    logic        per_ack;
    logic [31:0] per_rdata;

    modport master (
        output ram_addr, ram_we, ram_be, ram_wdata,
        input  ram_rdata,
        output per_req, per_we, per_addr, per_be, per_wdata,
        input  per_ack, per_rdata
    );

    modport slave (
        input  ram_addr, ram_we, ram_be, ram_wdata,
        output ram_rdata,
        input  per_req, per_we, per_addr, per_be, per_wdata,
        output per_ack, per_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. RAM accesses complete combinationally in one
// cycle; peripheral accesses run a req/ack handshake with a timeout and stall
// the pipeline until they finish. Only the FSM state and timeout counter are
// registered; everything else is combinational from the held M-stage inputs.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MemWriteM,
    input  logic [1:0]             ResultSrcM,
    input  logic [1:0]             MemSizeM,
    input  logic                   LoadUnsM,
    input  logic                   IsPerM,
    input  logic [31:0]            ALUResultM,
    input  logic [31:0]            WriteDataM,
    mem_stage_lsu_if.master        bus,
    output logic [31:0]            ReadDataM,
    output logic                   StallM,
    output logic                   MisalignM,
    output logic                   PerErrM
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_load, is_acc, misalign, start;
    logic        sz_byte, sz_half, sz_word;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] raw;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;
    logic        data_ok;
    logic        ack_w, last_w;

    // Access decode, alignment check, byte enables and lane-replicated store data
    always_comb begin
        is_load  = (ResultSrcM == 2'b01);
        is_acc   = is_load | MemWriteM;
        off      = ALUResultM[1:0];
        sz_byte  = (MemSizeM == 2'b00);
        sz_half  = (MemSizeM == 2'b01);
        sz_word  = MemSizeM[1];
        misalign = is_acc & ((sz_half & off[0]) | (sz_word & (off != 2'b00)));
        be       = '1;
        wdata    = WriteDataM;
        if (sz_byte) begin
            be    = 4'b0001 << off;
            wdata = {4{WriteDataM[7:0]}};
        end else if (sz_half) begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WriteDataM[15:0]}};
        end
        // Reset gating keeps the pipeline from seeing a stall while EXE/MEM clears
        start = rst & IsPerM & is_acc & ~misalign;
    end

    // Load extraction: pick the raw word source, select the lane, extend
    always_comb begin
        raw    = IsPerM ? bus.per_rdata : bus.ram_rdata;
        lane_b = raw[{off, 3'b000} +: 8];
        lane_h = off[1] ? raw[31:16] : raw[15:0];
        if (sz_byte) begin
            ext = {{24{~LoadUnsM & lane_b[7]}}, lane_b};
        end else if (sz_half) begin
            ext = {{16{~LoadUnsM & lane_h[15]}}, lane_h};
        end else begin
            ext = raw;
        end
    end

    // FSM state and timeout counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a handshake ends on ack or on the last permitted WAIT cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (bus.per_ack || (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: bus drives, stall, timeout pulse and load result
    always_comb begin
        ack_w  = (state_q == WAIT) & bus.per_ack;
        last_w = (state_q == WAIT) & (cnt_q == CNT_LAST);

        bus.ram_addr  = ALUResultM;
        bus.ram_we    = rst & MemWriteM & ~IsPerM & ~misalign;
        bus.ram_be    = be;
        bus.ram_wdata = wdata;

        bus.per_addr  = ALUResultM;
        bus.per_be    = be;
        bus.per_wdata = wdata;
        bus.per_req   = (state_q == WAIT);
        bus.per_we    = (state_q == WAIT) & MemWriteM;

        if (state_q == WAIT) begin
            StallM = ~ack_w & ~last_w;
        end else begin
            StallM = start;
        end
        PerErrM = last_w & ~ack_w;

        // RAM data is valid immediately; peripheral data only in the ack cycle
        data_ok   = ~IsPerM | ack_w;
        ReadDataM = (is_load & ~misalign & data_ok) ? ext : '0;
        MisalignM = misalign;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized RAM
// and peripheral traffic checked against a byte-level reference model.
module tb_mem_stage_lsu;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [1:0]  MemSizeM;
    logic        LoadUnsM;
    logic        IsPerM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        PerErrM;

    int pass_cnt;
    int total_cnt;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(
        .TIMEOUT (TMO),
        .CNT_W   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .MemSizeM   (MemSizeM),
        .LoadUnsM   (LoadUnsM),
        .IsPerM     (IsPerM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .bus        (bus),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .PerErrM    (PerErrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned m_nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
        int unsigned nb   = m_nbytes(sz);
        int unsigned base = addr % 4;
        base = base - (base % nb);
        return 4'(((1 << nb) - 1) << base);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int unsigned nb = m_nbytes(sz);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (32'((wd >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic bit m_mis(input bit acc, input logic [1:0] sz, input logic [31:0] addr);
        return acc && ((addr % m_nbytes(sz)) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] raw, input logic [1:0] sz,
                                           input logic [31:0] addr, input bit uns);
        int unsigned    nb = m_nbytes(sz);
        int unsigned    base;
        longint unsigned v;
        if (nb == 4) return raw;
        base = (addr % 4) - ((addr % 4) % nb);
        v = (longint'(raw) >> (8 * base)) % (64'd1 << (8 * nb));
        if (!uns && v >= (64'd1 << (8 * nb - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemSizeM   = 2'b00;
        LoadUnsM   = 1'b0;
        IsPerM     = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        bus.per_ack   = 1'b0;
        bus.per_rdata = '0;
        bus.ram_rdata = '0;
    endtask

    task automatic set_access(input bit wr, input bit per, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd, input bit uns);
        MemWriteM  = wr;
        ResultSrcM = wr ? 2'b00 : 2'b01;
        MemSizeM   = sz;
        LoadUnsM   = uns;
        IsPerM     = per;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        total_cnt++;
        if ({StallM, bus.per_req, PerErrM, bus.ram_we} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got stall/req/err/we=%b required 0000",
                     {StallM, bus.per_req, PerErrM, bus.ram_we});
        end else pass_cnt++;
        total_cnt++;
        if (ReadDataM !== 32'h0) $display("FAIL reset_rdata: got %h required 00000000", ReadDataM);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_directed();
        // byte store at 0x1002
        set_access(1'b1, 1'b0, 2'b00, 32'h1002, 32'h0000_00A5, 1'b0);
        @(negedge clk);
        total_cnt++;
        if ({bus.ram_we, bus.ram_be, StallM} !== {1'b1, 4'b0100, 1'b0})
            $display("FAIL sb_ctrl: got we/be/stall=%b required 101000", {bus.ram_we, bus.ram_be, StallM});
        else pass_cnt++;
        total_cnt++;
        if (bus.ram_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h required a5a5a5a5", bus.ram_wdata);
        else pass_cnt++;
        @(posedge clk); #1;

        // half loads
        bus.ram_rdata = 32'h8001_1234;
        set_access(1'b0, 1'b0, 2'b01, 32'h1002, 32'h0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (ReadDataM !== 32'hFFFF_8001) $display("FAIL lh_off2: got %h required ffff8001", ReadDataM);
        else pass_cnt++;
        LoadUnsM = 1'b1;
        #1;
        total_cnt++;
        if (ReadDataM !== 32'h0000_8001) $display("FAIL lhu_off2: got %h required 00008001", ReadDataM);
        else pass_cnt++;
        LoadUnsM   = 1'b0;
        ALUResultM = 32'h1000;
        #1;
        total_cnt++;
        if (ReadDataM !== 32'h0000_1234) $display("FAIL lh_off0: got %h required 00001234", ReadDataM);
        else pass_cnt++;
        @(posedge clk); #1;

        // misaligned word load to the peripheral region must not start anything
        set_access(1'b0, 1'b1, 2'b10, 32'h1001, 32'h0, 1'b0);
        bus.ram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        total_cnt++;
        if ({MisalignM, bus.ram_we, bus.per_req, StallM} !== 4'b1000 || ReadDataM !== 32'h0)
            $display("FAIL misalign: got mis/we/req/stall=%b rdata=%h required 1000 00000000",
                     {MisalignM, bus.ram_we, bus.per_req, StallM}, ReadDataM);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.per_req !== 1'b0) $display("FAIL misalign_nostart: got per_req=%b required 0", bus.per_req);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_ram_random();
        for (int n = 0; n < 300; n++) begin
            bit          wr, ld, uns, mis;
            logic [1:0]  sz;
            logic [31:0] addr, wd, rd, exp_rd;
            wr   = ($urandom % 3) == 0;
            ld   = !wr && ($urandom % 4) != 0;
            sz   = 2'($urandom);
            uns  = 1'($urandom);
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            MemWriteM  = wr;
            ResultSrcM = ld ? 2'b01 : 2'($urandom_range(0, 2) * ($urandom_range(0, 2) == 1 ? 0 : 1) + ($urandom % 2) * 2);
            if (!ld && ResultSrcM == 2'b01) ResultSrcM = 2'b10;
            MemSizeM   = sz;
            LoadUnsM   = uns;
            IsPerM     = 1'b0;
            ALUResultM = addr;
            WriteDataM = wd;
            bus.ram_rdata = rd;
            mis    = m_mis(wr || ld, sz, addr);
            exp_rd = (ld && !mis) ? m_load(rd, sz, addr, uns) : 32'h0;
            @(negedge clk);
            total_cnt++;
            if ({MisalignM, bus.ram_we, StallM, bus.per_req, PerErrM} !== {mis, wr && !mis, 3'b000})
                $display("FAIL ram_ctrl[%0d]: got mis/we/stall/req/err=%b required %b", n,
                         {MisalignM, bus.ram_we, StallM, bus.per_req, PerErrM}, {mis, wr && !mis, 3'b000});
            else pass_cnt++;
            total_cnt++;
            if ({bus.ram_be, bus.per_be} !== {2{m_be(sz, addr)}} ||
                {bus.ram_wdata, bus.per_wdata} !== {2{m_wdata(sz, wd)}} ||
                {bus.ram_addr, bus.per_addr} !== {2{addr}})
                $display("FAIL ram_bus[%0d]: got be=%b wdata=%h addr=%h required be=%b wdata=%h addr=%h", n,
                         bus.ram_be, bus.ram_wdata, bus.ram_addr, m_be(sz, addr), m_wdata(sz, wd), addr);
            else pass_cnt++;
            total_cnt++;
            if (ReadDataM !== exp_rd)
                $display("FAIL ram_rdata[%0d]: got %h required %h (sz=%0d addr=%h uns=%0d)", n,
                         ReadDataM, exp_rd, sz, addr, uns);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    // One peripheral access; ackw is the WAIT-cycle index of the ack, or -1 for none
    task automatic per_access(input string tag, input bit wr, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] prd, input bit uns, input int ackw);
        bit done;
        set_access(wr, 1'b1, sz, addr, wd, uns);
        bus.per_ack   = 1'b0;
        bus.per_rdata = $urandom;
        @(negedge clk);
        total_cnt++;
        if ({StallM, bus.per_req, PerErrM} !== 3'b100 || ReadDataM !== 32'h0)
            $display("FAIL %s_start: got stall/req/err=%b rdata=%h required 100 00000000", tag,
                     {StallM, bus.per_req, PerErrM}, ReadDataM);
        else pass_cnt++;
        @(posedge clk); #1;
        done = 1'b0;
        for (int w = 0; w < int'(TMO) && !done; w++) begin
            bit          hit, last, e_stall, e_err;
            logic [31:0] e_rd;
            hit  = (w == ackw);
            last = (w == int'(TMO) - 1);
            bus.per_ack   = hit;
            bus.per_rdata = hit ? prd : $urandom;
            e_stall = !(hit || last);
            e_err   = last && !hit;
            e_rd    = (hit && !wr) ? m_load(prd, sz, addr, uns) : 32'h0;
            @(negedge clk);
            total_cnt++;
            if ({StallM, bus.per_req, bus.per_we, PerErrM, bus.ram_we} !== {e_stall, 1'b1, wr, e_err, 1'b0})
                $display("FAIL %s_wait%0d: got stall/req/we/err/ramwe=%b required %b", tag, w,
                         {StallM, bus.per_req, bus.per_we, PerErrM, bus.ram_we},
                         {e_stall, 1'b1, wr, e_err, 1'b0});
            else pass_cnt++;
            total_cnt++;
            if (bus.per_be !== m_be(sz, addr) || bus.per_wdata !== m_wdata(sz, wd) ||
                bus.per_addr !== addr || ReadDataM !== e_rd)
                $display("FAIL %s_data%0d: got be=%b wdata=%h addr=%h rdata=%h required be=%b wdata=%h addr=%h rdata=%h",
                         tag, w, bus.per_be, bus.per_wdata, bus.per_addr, ReadDataM,
                         m_be(sz, addr), m_wdata(sz, wd), addr, e_rd);
            else pass_cnt++;
            @(posedge clk); #1;
            done = hit || last;
        end
        idle_inputs();
        @(negedge clk);
        total_cnt++;
        if ({bus.per_req, StallM, PerErrM} !== 3'b000)
            $display("FAIL %s_end: got req/stall/err=%b required 000", tag, {bus.per_req, StallM, PerErrM});
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_per_directed();
        per_access("pld_ack3", 1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        per_access("pst_tmo", 1'b1, 2'b10, 32'h8000_0020, 32'h1234_5678, 32'h0, 1'b0, -1);
        per_access("pst_lastack", 1'b1, 2'b10, 32'h8000_0020, 32'h1234_5678, 32'h0, 1'b0, int'(TMO) - 1);
        per_access("pld_min", 1'b0, 2'b00, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 0);
    endtask

    task automatic test_ack_in_idle();
        idle_inputs();
        bus.per_ack = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.per_req, StallM, PerErrM} !== 3'b000)
            $display("FAIL idle_ack: got req/stall/err=%b required 000", {bus.per_req, StallM, PerErrM});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.per_req !== 1'b0) $display("FAIL idle_ack_next: got per_req=%b required 0", bus.per_req);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_per_random();
        for (int n = 0; n < 25; n++) begin
            logic [1:0]  sz;
            logic [31:0] addr;
            sz   = 2'($urandom);
            addr = $urandom;
            addr = addr - (addr % m_nbytes(sz));
            per_access("prnd", 1'($urandom), sz, addr, $urandom, $urandom, 1'($urandom),
                       int'($urandom_range(0, TMO + 1)));
        end
    endtask

    task automatic test_back_to_back();
        per_access("b2b_a", 1'b0, 2'b01, 32'h9000_0002, 32'h0, 32'h7FFF_8000, 1'b1, 0);
        per_access("b2b_b", 1'b1, 2'b00, 32'h9000_0001, 32'h0000_003C, 32'h0, 1'b0, 1);
    endtask

    task automatic test_reset_mid();
        set_access(1'b0, 1'b1, 2'b10, 32'h8000_0040, 32'h0, 1'b0);
        bus.per_ack = 1'b0;
        @(posedge clk); #1;      // now in WAIT, cnt 0
        @(posedge clk); #1;      // 2nd WAIT cycle
        @(negedge clk);
        total_cnt++;
        if ({bus.per_req, StallM} !== 2'b11)
            $display("FAIL rstmid_pre: got req/stall=%b required 11", {bus.per_req, StallM});
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({bus.per_req, StallM, PerErrM} !== 3'b000)
            $display("FAIL rstmid_async: got req/stall/err=%b required 000", {bus.per_req, StallM, PerErrM});
        else pass_cnt++;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        // full timeout after release proves the counter restarted at zero
        per_access("rstmid_after", 1'b0, 2'b10, 32'h8000_0044, 32'h0, 32'h0, 1'b0, -1);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_ram_directed();
        test_ram_random();
        test_per_directed();
        test_ack_in_idle();
        test_per_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Sits directly downstream of the EXE/MEM pipeline register and consumes its M-stage outputs.
- Data RAM accesses (IsPerM=0) complete in a single cycle against an asynchronous-read RAM port. Peripheral accesses (IsPerM=1) run a req/ack handshake with a timeout, and the unit raises StallM to the hazard unit until they complete.
- Generates byte enables and lane-replicated store data, and produces sign- or zero-extended load data (ReadDataM) for the MEM/WB register.

Parameters:
- TIMEOUT, 16, maximum number of WAIT cycles for per_ack before the access is aborted (must be ≥1).
- CNT_W, 5, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store in M stage.
- ResultSrcM  in  2  01 = load; other values mean no memory read.
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- LoadUnsM  in  1  1 = zero-extend (LBU/LHU).
- IsPerM  in  1  access targets the peripheral bus.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, low-aligned.
- ram_addr  out  32  equal to ALUResultM.
- ram_we  out  1  RAM write strobe.
- ram_be  out  4  RAM byte enables.
- ram_wdata  out  32  lane-replicated store data.
- ram_rdata  in  32  RAM word, asynchronous read.
- per_req  out  1  peripheral request.
- per_we  out  1  peripheral write.
- per_addr  out  32  equal to ALUResultM.
- per_be  out  4  peripheral byte enables.
- per_wdata  out  32  lane-replicated store data.
- per_ack  in  1  peripheral completion, sampled only in WAIT.
- per_rdata  in  32  valid in the cycle per_ack=1.
- ReadDataM  out  32  extended load result.
- StallM  out  1  hold EXE/MEM and upstream stages.
- MisalignM  out  1  misaligned access flag, combinational.
- PerErrM  out  1  peripheral timeout pulse.

Behaviour:
- Definitions:
  - load = (ResultSrcM==01); acc = load | MemWriteM.
  - off = ALUResultM[1:0].
  - misalign = acc & ((half & off[0]) | (word & off!=0)).
  - MisalignM = misalign.
- Misaligned accesses:
  - ram_we=0, per_req=0, ReadDataM=0, no stall.
- Byte enables and store data:
  - byte: be = 0001 << off; wdata = {4{WriteDataM[7:0]}}.
  - half: be = off[1] ? 1100 : 0011; wdata = {2{WriteDataM[15:0]}}.
  - word: be = 1111; wdata = WriteDataM.
- RAM path:
  - ram_we = MemWriteM & !IsPerM & !misalign.
  - ram_be is always driven as computed above.
  - Load data comes from ram_rdata in the same cycle; zero added latency, StallM=0.
- Load extraction (applied to the selected raw word):
  - byte: lane off; sign-extend from bit 7 unless LoadUnsM.
  - half: lane off[1]; sign-extend from bit 15 unless LoadUnsM.
  - word: pass-through.
  - Non-load: ReadDataM = 0.
- Peripheral FSM (states IDLE, WAIT; timeout counter cnt):
  - IDLE:
    - start = IsPerM & acc & !misalign.
    - StallM = start; per_req = 0.
    - If start, go to WAIT next edge with cnt=0.
  - WAIT:
    - per_req = 1; per_we = MemWriteM.
    - per_addr, per_be and per_wdata are driven from the held M inputs, which are stable because StallM holds EXE/MEM.
    - If per_ack: StallM=0, raw word = per_rdata, next state IDLE.
    - Else if cnt == TIMEOUT-1: StallM=0, PerErrM=1 for this cycle, ReadDataM=0, next state IDLE.
    - Else: StallM=1, cnt+1.
  - Minimum peripheral latency is 2 cycles: the start cycle plus an ack in the first WAIT cycle, with StallM high for exactly 1 cycle.
  - Back-to-back peripheral accesses pass through IDLE between them, so there is always one start cycle per access.
  - An ack seen in IDLE is ignored.
  - An ack arriving in the same cycle as cnt==TIMEOUT-1 counts as success; PerErrM stays 0.
- Reset (rst=0, asynchronous, at any time including mid-handshake):
  - state = IDLE, cnt = 0, so per_req=0 and PerErrM=0 immediately.
  - The EXE/MEM register also clears, giving StallM=0, ram_we=0 and ReadDataM=0.
  - An in-flight peripheral transaction is abandoned.
- All outputs other than the FSM state and counter are combinational.

Test Plan:
- RAM store byte: ALUResultM=0x1002, MemSizeM=00, WriteDataM=0x000000A5 → ram_we=1, ram_be=0100, ram_wdata=0xA5A5A5A5, StallM=0.
- RAM load half signed: off=2, ram_rdata=0x8001_1234, LoadUnsM=0 → ReadDataM=0xFFFF8001. With LoadUnsM=1 → 0x00008001. With off=0, signed → 0x00001234.
- Misaligned word load at 0x1001 → MisalignM=1, ReadDataM=0, ram_we=0, per_req=0, StallM=0.
- Peripheral load, ack after 3 WAIT cycles, per_rdata=0xDEADBEEF, word → StallM high 3 cycles (start + 2 WAIT), drops in the ack cycle with ReadDataM=0xDEADBEEF; per_req high for 3 cycles; back in IDLE next cycle.
- Peripheral store with no ack, TIMEOUT=4 → StallM high 4 cycles, PerErrM=1 in the 5th cycle with StallM=0; then IDLE. Same run with ack in that 5th cycle → PerErrM=0.
- rst asserted in the 2nd WAIT cycle → per_req and StallM go to 0 without waiting for a clock edge; after release, a new peripheral access starts from IDLE with cnt=0.
